axil_master_ctrl: RTL

AXIL_MASTER_CTRL -- requirements
Module: axil_master_ctrl

---
 rtl/axil_master_ctrl.sv | 180 ++++++++++++++++++
 1 files changed

// File: rtl/axil_master_ctrl.sv
// Single-outstanding AXI4-Lite master: turns one command into one AXI read or write
// and returns one response. Optional stall watchdog under AXIL_MASTER_TIMEOUT_EN.
module axil_master_ctrl #(
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        M_AXI_ACLK,
    input  logic        M_AXI_ARESETN,
    // command
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_write,
    input  logic [31:0] cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [3:0]  cmd_wstrb,
    // response
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic [1:0]  rsp_resp,
    output logic        rsp_write,
    // AXI-Lite write channels
    output logic [31:0] M_AXI_AWADDR,
    output logic        M_AXI_AWVALID,
    input  logic        M_AXI_AWREADY,
    output logic [31:0] M_AXI_WDATA,
    output logic [3:0]  M_AXI_WSTRB,
    output logic        M_AXI_WVALID,
    input  logic        M_AXI_WREADY,
    input  logic [1:0]  M_AXI_BRESP,
    input  logic        M_AXI_BVALID,
    output logic        M_AXI_BREADY,
    // AXI-Lite read channels
    output logic [31:0] M_AXI_ARADDR,
    output logic        M_AXI_ARVALID,
    input  logic        M_AXI_ARREADY,
    input  logic [31:0] M_AXI_RDATA,
    input  logic [1:0]  M_AXI_RRESP,
    input  logic        M_AXI_RVALID,
    output logic        M_AXI_RREADY,
    output logic        timeout_flag
);

    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        WADDR_DATA = 3'd1,
        WRESP      = 3'd2,
        RADDR      = 3'd3,
        RDATA      = 3'd4,
        RSP        = 3'd5
    } state_t;

    state_t      r_state, w_next;
    logic        r_awvalid, r_wvalid, r_arvalid;
    logic [31:0] r_addr, r_wdata, r_rdata;
    logic [3:0]  r_wstrb;
    logic [1:0]  r_resp;
    logic        r_write;
    logic        w_accept;
    logic        w_aw_done, w_w_done;

    assign w_accept  = cmd_valid & cmd_ready;
    // A channel is finished once its VALID has dropped or is handshaking now.
    assign w_aw_done = ~r_awvalid | M_AXI_AWREADY;
    assign w_w_done  = ~r_wvalid  | M_AXI_WREADY;

    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) r_state <= IDLE;
        else                r_state <= w_next;
    end

    always_comb begin
        w_next       = r_state;
        cmd_ready    = 1'b0;
        M_AXI_BREADY = 1'b0;
        M_AXI_RREADY = 1'b0;
        rsp_valid    = 1'b0;
        case (r_state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) w_next = cmd_write ? WADDR_DATA : RADDR;
            end
            WADDR_DATA: if (w_aw_done && w_w_done) w_next = WRESP;
            WRESP: begin
                M_AXI_BREADY = 1'b1;
                if (M_AXI_BVALID) w_next = RSP;
            end
            RADDR: if (M_AXI_ARREADY) w_next = RDATA;
            RDATA: begin
                M_AXI_RREADY = 1'b1;
                if (M_AXI_RVALID) w_next = RSP;
            end
            RSP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // VALIDs are registered so they never see READY combinationally.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_awvalid <= 1'b0;
            r_wvalid  <= 1'b0;
            r_arvalid <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
            r_wstrb   <= '0;
            r_write   <= 1'b0;
            r_rdata   <= '0;
            r_resp    <= '0;
        end else begin
            if (w_accept) begin
                r_addr    <= cmd_addr;
                r_wdata   <= cmd_wdata;
                r_wstrb   <= cmd_wstrb;
                r_write   <= cmd_write;
                r_awvalid <= cmd_write;
                r_wvalid  <= cmd_write;
                r_arvalid <= ~cmd_write;
            end else begin
                if (r_awvalid && M_AXI_AWREADY) r_awvalid <= 1'b0;
                if (r_wvalid  && M_AXI_WREADY)  r_wvalid  <= 1'b0;
                if (r_arvalid && M_AXI_ARREADY) r_arvalid <= 1'b0;
            end
            if (r_state == WRESP && M_AXI_BVALID) begin
                r_rdata <= '0;
                r_resp  <= M_AXI_BRESP;
            end
            if (r_state == RDATA && M_AXI_RVALID) begin
                r_rdata <= M_AXI_RDATA;
                r_resp  <= M_AXI_RRESP;
            end
        end
    end

    assign M_AXI_AWADDR  = r_addr;
    assign M_AXI_ARADDR  = r_addr;
    assign M_AXI_WDATA   = r_wdata;
    assign M_AXI_WSTRB   = r_wstrb;
    assign M_AXI_AWVALID = r_awvalid;
    assign M_AXI_WVALID  = r_wvalid;
    assign M_AXI_ARVALID = r_arvalid;
    assign rsp_rdata     = r_rdata;
    assign rsp_resp      = r_resp;
    assign rsp_write     = r_write;

`ifdef AXIL_MASTER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [CNT_W-1:0] r_to_cnt;
    logic             r_timeout;
    logic             w_busy;

    assign w_busy = (r_state == WADDR_DATA) || (r_state == WRESP) ||
                    (r_state == RADDR)      || (r_state == RDATA);

    // Flag is sticky across the rest of the transaction; only a new command clears it.
    always_ff @(posedge M_AXI_ACLK or negedge M_AXI_ARESETN) begin
        if (!M_AXI_ARESETN) begin
            r_to_cnt  <= '0;
            r_timeout <= 1'b0;
        end else begin
            if (!w_busy)
                r_to_cnt <= '0;
            else if (r_to_cnt != CNT_W'(TIMEOUT_CYCLES))
                r_to_cnt <= r_to_cnt + CNT_W'(1);
            if (w_accept)
                r_timeout <= 1'b0;
            else if (w_busy && r_to_cnt == CNT_W'(TIMEOUT_CYCLES - 1))
                r_timeout <= 1'b1;
        end
    end

    assign timeout_flag = r_timeout;
`else
    assign timeout_flag = 1'b0;
`endif

endmodule
